// File: rtl/sabr_udiv_79ns_36ns_43_seq.sv
// Sequential restoring divider: 79-bit dividend / 36-bit divisor -> 43-bit quotient, 36-bit remainder.
// Define SABR_UDIV_EARLY_EXIT_EN to skip leading-zero iterations when the dividend's upper half is zero.
module sabr_udiv_79ns_36ns_43_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 79,
  parameter int din1_WIDTH = 36,
  parameter int dout_WIDTH = 43
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div0,
  output logic                  ovf
);

  localparam int DW = din1_WIDTH;
  localparam int QW = dout_WIDTH;
  localparam int NW = din0_WIDTH;
  localparam int CW = $clog2(QW + 1);

  if (NW != DW + QW || ID < 0) begin : g_badConfig
    $error("sabr_udiv: dividend width must equal divisor width plus quotient width");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_rem;
  logic [QW-1:0] r_low;
  logic          r_busy;
  logic          r_done;
  logic [QW-1:0] r_dout;
  logic [DW-1:0] r_remOut;
  logic          r_div0;
  logic          r_ovf;

  logic [DW-1:0] w_hi;
  logic [QW-1:0] w_lo;
  logic [DW:0]   w_shift;
  logic          w_ge;
  logic [DW-1:0] w_sub;
  logic [CW-1:0] w_skip;
  logic [CW-1:0] w_loadCount;
  logic [QW-1:0] w_loadLow;

  assign w_hi = din0[NW-1:QW];
  assign w_lo = din0[QW-1:0];

  // Quotient bits are shifted into the free LSBs of r_low as dividend bits leave the top.
  assign w_shift = {r_rem, r_low[QW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[DW-1:0] - r_div;

`ifdef SABR_UDIV_EARLY_EXIT_EN
  function automatic logic [CW-1:0] leadZeros(input logic [QW-1:0] v);
    logic [CW-1:0] cnt;
    logic          found;
    cnt   = '0;
    found = 1'b0;
    for (int i = QW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + CW'(1);
      end
    end
    return cnt;
  endfunction

  // Leading zeros only yield zero quotient bits while the partial remainder is still zero.
  assign w_skip = (w_hi == '0 && din1 != '0) ? leadZeros(w_lo) : '0;
`else
  assign w_skip = '0;
`endif

  assign w_loadCount = CW'(QW) - w_skip;
  assign w_loadLow   = w_lo << w_skip;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_low    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dout   <= '0;
      r_remOut <= '0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_div   <= din1;
            r_rem   <= w_hi;
            r_low   <= w_loadLow;
            r_count <= w_loadCount;
            r_busy  <= 1'b1;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
            if (din1 == '0) begin
              r_div0  <= 1'b1;
              r_state <= S_DONE;
            end else if (w_hi >= din1) begin
              r_ovf   <= 1'b1;
              r_state <= S_DONE;
            end else if (w_loadCount == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_low   <= {r_low[QW-2:0], w_ge};
          r_rem   <= w_ge ? w_sub : w_shift[DW-1:0];
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          // On div0 r_low was never shifted, so it still holds the dividend's low bits.
          if (r_div0) begin
            r_dout   <= '1;
            r_remOut <= r_low[DW-1:0];
          end else if (r_ovf) begin
            r_dout   <= '1;
            r_remOut <= '0;
          end else begin
            r_dout   <= r_low;
            r_remOut <= r_rem;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;
  assign rem  = r_remOut;
  assign div0 = r_div0;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_sabr_udiv_79ns_36ns_43_seq.sv
// Scoreboard bench for sabr_udiv_79ns_36ns_43_seq: expected results are queued at accept and compared at done.
module tb_sabr_udiv_79ns_36ns_43_seq;

  logic        apClk = 1'b0;
  logic        apRst;
  logic        ce;
  logic        start;
  logic [78:0] din0;
  logic [35:0] din1;
  logic        busy;
  logic        done;
  logic [42:0] dout;
  logic [35:0] rem;
  logic        div0;
  logic        ovf;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [42:0] q;
    logic [35:0] r;
    logic        d0;
    logic        ov;
    int          lat;
  } exp_t;

  exp_t expQ[$];

  sabr_udiv_79ns_36ns_43_seq dut (
    .ap_clk(apClk),
    .ap_rst(apRst),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .div0  (div0),
    .ovf   (ovf)
  );

  always #5 apClk = ~apClk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic int expLatency(input logic [78:0] a);
    int k;
    k = 0;
`ifdef SABR_UDIV_EARLY_EXIT_EN
    if (a[78:43] == '0) begin
      for (int i = 42; i >= 0; i--) begin
        if (a[i]) break;
        k++;
      end
    end
`endif
    return 44 - k;
  endfunction

  function automatic exp_t model(input logic [78:0] a, input logic [35:0] b);
    exp_t        e;
    logic [78:0] q79;
    logic [78:0] r79;
    e.d0 = 1'b0;
    e.ov = 1'b0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a[35:0];
      e.d0  = 1'b1;
      e.lat = 1;
    end else if (a[78:43] >= b) begin
      e.q   = '1;
      e.r   = '0;
      e.ov  = 1'b1;
      e.lat = 1;
    end else begin
      q79   = a / {43'd0, b};
      r79   = a % {43'd0, b};
      e.q   = q79[42:0];
      e.r   = r79[35:0];
      e.lat = expLatency(a);
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [78:0] a, input logic [35:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    ce    = 1'b1;
    @(posedge apClk);
    expQ.push_back(model(a, b));
    @(negedge apClk);
    start = 1'b0;
    checkOutput("busy_after_accept", busy, 1'b1);
  endtask

  task automatic runOp(input string name, input logic [78:0] a, input logic [35:0] b,
                       input int stallAt, input int stallLen, input int pulseAt);
    int   n;
    int   wantLat;
    exp_t e;
    applyStimulus(a, b);
    n = 0;
    while (n < 300) begin
      if (done) break;
      ce    = !((n + 1) >= stallAt && (n + 1) < stallAt + stallLen);
      start = ((n + 1) == pulseAt);
      @(posedge apClk);
      n++;
      @(negedge apClk);
    end
    ce    = 1'b1;
    start = 1'b0;
    e = expQ.pop_front();
    if (!done) begin
      checkOutput({name, "_done_timeout"}, done, 1'b1);
      return;
    end
    wantLat = e.lat + ((stallLen > 0 && stallAt <= e.lat) ? stallLen : 0);
    checkOutput({name, "_latency"}, n, wantLat);
    checkOutput({name, "_dout"}, dout, e.q);
    checkOutput({name, "_rem"}, rem, e.r);
    checkOutput({name, "_div0"}, div0, e.d0);
    checkOutput({name, "_ovf"}, ovf, e.ov);
    checkOutput({name, "_busy_at_done"}, busy, 1'b0);
    @(posedge apClk);
    @(negedge apClk);
    checkOutput({name, "_done_one_cycle"}, done, 1'b0);
    checkOutput({name, "_dout_hold"}, dout, e.q);
  endtask

  task automatic expectNoDone(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge apClk);
      if (done) seen++;
    end
    checkOutput({name, "_no_done"}, seen, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rndA;
    logic [63:0] rndB;
    logic [35:0] b;
    logic [35:0] hi;
    logic [42:0] lo;
    logic [78:0] a;

    apRst = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(posedge apClk);
    @(negedge apClk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_dout", dout, 43'd0);
    checkOutput("reset_rem", rem, 36'd0);
    checkOutput("reset_div0", div0, 1'b0);
    checkOutput("reset_ovf", ovf, 1'b0);
    apRst = 1'b0;
    ce    = 1'b1;
    @(negedge apClk);

    runOp("basic_100_7", 79'd100, 36'd7, 0, 0, 0);
    checkOutput("basic_100_7_q_const", dout, 43'd14);
    checkOutput("basic_100_7_r_const", rem, 36'd2);

    a = {36'hFFFFFFFFF, 43'd0} - 79'd1;
    runOp("max_quotient", a, 36'hFFFFFFFFF, 0, 0, 0);
    checkOutput("max_quotient_q_const", dout, {43{1'b1}});
    checkOutput("max_quotient_r_const", rem, 36'hFFFFFFFFE);

    a = '0;
    a[78] = 1'b1;
    runOp("ovf_pow78", a, 36'd1, 0, 0, 0);
    runOp("ovf_equal", {36'd5, 43'd0}, 36'd5, 0, 0, 0);
    runOp("div0", 79'h1234, 36'd0, 0, 0, 0);
    runOp("zero_dividend", 79'd0, 36'd5, 0, 0, 0);

    runOp("stall", 79'd100, 36'd7, 20, 5, 10);
    expectNoDone("stall_after", 60);

    applyStimulus(79'd100, 36'd7);
    void'(expQ.pop_back());
    repeat (19) @(negedge apClk);
    apRst = 1'b1;
    @(posedge apClk);
    @(negedge apClk);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_done", done, 1'b0);
    checkOutput("midreset_dout", dout, 43'd0);
    checkOutput("midreset_rem", rem, 36'd0);
    apRst = 1'b0;
    expectNoDone("midreset", 60);
    runOp("after_reset_9_3", 79'd9, 36'd3, 0, 0, 0);

    for (int t = 0; t < 4; t++) begin
      rndA = {$urandom(), $urandom()};
      rndB = {$urandom(), $urandom()};
      b  = rndB[35:0];
      if (b == '0) b = 36'd1;
      hi = rndB[63:28] % b;
      lo = rndA[42:0];
      runOp($sformatf("random%0d", t), {hi, lo}, b, 0, 0, 0);
    end

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
